fft_bitrev_reorder: RTL



---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_bitrev_reorder_if.sv | 23 ++
 rtl/fft_reorder_ram.sv | 36 +++
 rtl/fft_bitrev_reorder.sv | 116 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT helpers: integer log2, index bit reversal, and the complex sample type.
package fft_pkg;

  localparam int FFT_WIDTH = 16;

  // Complex sample at the default component width.
  typedef struct packed {
    logic [FFT_WIDTH-1:0] re;
    logic [FFT_WIDTH-1:0] im;
  } cplx_t;

  // Ceiling log2. Elaboration-time use for power-of-two sizes.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of 'value'. Higher bits of the result are zero.
  function automatic int bitrev(input int value, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[i] = value[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample streams around the reorder stage: bit-reversed input, natural-order output.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 16
);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;

  // Upstream SDF chain / downstream consumer side.
  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im
  );

  // Reorder stage side.
  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im
  );
endinterface

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
// Written so synthesis maps it onto block RAM.
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32,
  localparam int ADDR_W = log2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port.
  // NOTE: the array and read register have no reset; a reset would stop block-RAM inference and the contents are never relied on before written.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port, one cycle of latency.
  // NOTE: non-blocking assignment keeps read-before-write ordering well defined against the write block.
  always_ff @(posedge clock) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage behind the last SDF stage.
// Frames are captured into one bank of a ping-pong RAM at the bit-reversed
// address and replayed from the other bank in natural order.
// Optional: define FFT_REORDER_XPROP_EN to drive do_re/do_im to x while do_en = 0.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  fft_bitrev_reorder_if.slave bus
);

  localparam int LOG_N = log2(N);
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_active_q, rd_active_d;
  logic             rd_valid_q;
  logic             do_en_q;
  sample_t          ram_rd;
  sample_t          do_q;
  logic             frame_done;
  logic [LOG_N:0]   wr_addr;
  logic [LOG_N:0]   rd_addr;

  assign frame_done = bus.di_en && (wr_cnt_q == LAST);
  assign wr_addr    = {wr_bank_q, LOG_N'(bitrev(int'(wr_cnt_q), LOG_N))};
  assign rd_addr    = {rd_bank_q, rd_cnt_q};

  // Next-state for write counter, banks and read sequencer.
  // NOTE: every next-state signal is defaulted first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_cnt_d    = '0;
    wr_bank_d   = wr_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;

    // A low di_en discards any partial frame: counter restarts in the same bank.
    if (bus.di_en) begin
      wr_cnt_d = wr_cnt_q + LOG_N'(1);
      if (frame_done) wr_bank_d = ~wr_bank_q;
    end

    // A completion takes priority so it can land on the last read cycle of the previous frame without a gap.
    if (frame_done) begin
      rd_active_d = 1'b1;
      rd_bank_d   = wr_bank_q;
      rd_cnt_d    = '0;
    end else if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + LOG_N'(1);
      if (rd_cnt_q == LAST) rd_active_d = 1'b0;
    end
  end

  // Control state and output-valid pipeline; reset drops do_en immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      do_en_q     <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      rd_valid_q  <= rd_active_q;
      do_en_q     <= rd_valid_q;
    end
  end

  // Output data register; loads only on valid RAM data so it holds the last sample.
  always_ff @(posedge clock) begin
    if (rd_valid_q) do_q <= ram_rd;
  end

  fft_reorder_ram #(
    .DEPTH  (2 * N),
    .DATA_W (2 * WIDTH)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (bus.di_en),
    .wr_addr_i (wr_addr),
    .wr_data_i ({bus.di_re, bus.di_im}),
    .rd_en_i   (rd_active_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd)
  );

  assign bus.do_en = do_en_q;

`ifdef FFT_REORDER_XPROP_EN
  assign bus.do_re = do_en_q ? do_q.re : 'x;
  assign bus.do_im = do_en_q ? do_q.im : 'x;
`else
  assign bus.do_re = do_q.re;
  assign bus.do_im = do_q.im;
`endif

endmodule
